// File: rtl/ncl_pkg.sv
// Shared types and rail codes for the clocked NCL pipeline stage.
// Rail pair ordering is {true_rail, false_rail}.
package ncl_pkg;

   typedef enum logic [1:0] {
      NULL_HELD = 2'd0,
      DATA_HELD = 2'd1,
      ERROR     = 2'd2
   } ncl_state_e;

   localparam logic [1:0] RAIL_NULL = 2'b00;
   localparam logic [1:0] RAIL_F    = 2'b01;
   localparam logic [1:0] RAIL_T    = 2'b10;
   localparam logic [1:0] RAIL_ILL  = 2'b11;

   localparam int unsigned TOK_W = 16;

   function automatic logic rail_valid(
      input logic [1:0] pair
   );
      return (pair == RAIL_F) ||
             (pair == RAIL_T);
   endfunction

endpackage

// File: rtl/ncl_completion.sv
// Combinational completion and illegal-code detection
// across every dual-rail pair of the stage input.
module ncl_completion
   import ncl_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic [2*WIDTH-1:0] din,
   output logic               data_cmp,
   output logic               null_cmp,
   output logic               illegal
);

   logic [1:0] pair;

   always_comb begin
      data_cmp = 1'b1;
      null_cmp = 1'b1;
      illegal  = 1'b0;
      pair     = RAIL_NULL;
      for (int i = 0; i < WIDTH; i++) begin
         pair = din[2*i +: 2];
         if (!rail_valid(pair)) begin
            data_cmp = 1'b0;
         end
         if (pair != RAIL_NULL) begin
            null_cmp = 1'b0;
         end
         if (pair == RAIL_ILL) begin
            illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ncl_stage_sync.sv
// Clocked NCL register stage: a synchronous C-element over
// input completion and downstream acknowledges, with error trap.
module ncl_stage_sync
   import ncl_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int N_ACK = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*WIDTH-1:0] din,
   input  logic [N_ACK-1:0]   ack_in,
   output logic [2*WIDTH-1:0] dout,
   output logic               ack_out,
   output logic               err,
   output logic [15:0]        tok_cnt
);

   logic data_cmp;
   logic null_cmp;
   logic illegal;
   logic ack_all;
   logic ack_none;

   ncl_state_e         state_q, state_d;
   logic [2*WIDTH-1:0] dout_q, dout_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [TOK_W-1:0]   cnt_q, cnt_d;

   ncl_completion #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .din      (din),
      .data_cmp (data_cmp),
      .null_cmp (null_cmp),
      .illegal  (illegal)
   );

   assign ack_all  = &ack_in;
   assign ack_none = ~|ack_in;

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         NULL_HELD: begin
            if (illegal) begin
               state_d = ERROR;
               dout_d  = '0;
            end else if (data_cmp && ack_none) begin
               state_d = DATA_HELD;
               dout_d  = din;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         DATA_HELD: begin
            if (illegal) begin
               state_d = ERROR;
               dout_d  = '0;
            end else if (null_cmp && ack_all) begin
               state_d = NULL_HELD;
               dout_d  = '0;
            end
         end
         ERROR: begin
            dout_d = '0;
         end
         default: begin
            state_d = ERROR;
            dout_d  = '0;
         end
      endcase
      // Status flags are registered so every output comes off a flop.
      ack_d = (state_d == DATA_HELD);
      err_d = (state_d == ERROR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NULL_HELD;
         dout_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout    = dout_q;
   assign ack_out = ack_q;
   assign err     = err_q;
   assign tok_cnt = cnt_q;

endmodule

// File: tb/tb_ncl_stage_sync.sv
// Directed self-checking bench for ncl_stage_sync
// with WIDTH=3 dual-rail bits and two acknowledging consumers.
module tb_ncl_stage_sync;

   localparam int WIDTH = 3;
   localparam int N_ACK = 2;

   logic               clk;
   logic               rst;
   logic [2*WIDTH-1:0] din;
   logic [N_ACK-1:0]   ack_in;
   logic [2*WIDTH-1:0] dout;
   logic               ack_out;
   logic               err;
   logic [15:0]        tok_cnt;

   int checks;
   int failures;

   ncl_stage_sync #(
      .WIDTH (WIDTH),
      .N_ACK (N_ACK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .ack_in  (ack_in),
      .dout    (dout),
      .ack_out (ack_out),
      .err     (err),
      .tok_cnt (tok_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic token(input logic [5:0] d);
      din    = d;
      ack_in = 2'b00;
      step();
      din    = 6'b000000;
      ack_in = 2'b11;
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      din      = '0;
      ack_in   = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_ack", 32'(ack_out), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_cnt", 32'(tok_cnt), 32'h0);

      step();
      check("null_idle_ack", 32'(ack_out), 32'h0);

      // mixed ack blocks capture
      din    = 6'b100110;
      ack_in = 2'b10;
      step();
      check("mixed_ack_hold", 32'(ack_out), 32'h0);
      check("mixed_ack_cnt", 32'(tok_cnt), 32'h0);

      ack_in = 2'b00;
      step();
      check("cap_dout", 32'(dout), 32'h26);
      check("cap_ack", 32'(ack_out), 32'h1);
      check("cap_cnt", 32'(tok_cnt), 32'h1);

      din    = 6'b000000;
      ack_in = 2'b01;
      for (int i = 0; i < 5; i++) step();
      check("hold_ack", 32'(ack_out), 32'h1);
      check("hold_dout", 32'(dout), 32'h26);

      ack_in = 2'b11;
      step();
      check("null_dout", 32'(dout), 32'h0);
      check("null_ack", 32'(ack_out), 32'h0);
      check("null_cnt", 32'(tok_cnt), 32'h1);

      ack_in = 2'b00;
      din    = 6'b100100;
      for (int i = 0; i < 4; i++) step();
      check("partial_ack", 32'(ack_out), 32'h0);
      check("partial_dout", 32'(dout), 32'h0);
      check("partial_cnt", 32'(tok_cnt), 32'h1);

      din = 6'b100101;
      step();
      check("cap2_dout", 32'(dout), 32'h25);
      check("cap2_ack", 32'(ack_out), 32'h1);
      check("cap2_cnt", 32'(tok_cnt), 32'h2);

      din = 6'b110110;
      step();
      check("ill_err", 32'(err), 32'h1);
      check("ill_dout", 32'(dout), 32'h0);
      check("ill_ack", 32'(ack_out), 32'h0);

      din    = 6'b000000;
      ack_in = 2'b11;
      step();
      din    = 6'b010101;
      ack_in = 2'b00;
      step();
      check("absorb_err", 32'(err), 32'h1);
      check("absorb_ack", 32'(ack_out), 32'h0);
      check("absorb_dout", 32'(dout), 32'h0);
      check("absorb_cnt", 32'(tok_cnt), 32'h2);

      rst = 1'b1;
      step();
      rst = 1'b0;
      check("exit_err", 32'(err), 32'h0);
      check("exit_cnt", 32'(tok_cnt), 32'h0);

      // illegal while NULL_HELD
      din = 6'b000011;
      step();
      check("ill_null_err", 32'(err), 32'h1);
      rst = 1'b1;
      din = 6'b000000;
      step();
      rst = 1'b0;

      // reset beats the NULL transition
      din    = 6'b011010;
      ack_in = 2'b00;
      step();
      check("r30_pre_ack", 32'(ack_out), 32'h1);
      check("r30_pre_cnt", 32'(tok_cnt), 32'h1);
      rst    = 1'b1;
      din    = 6'b000000;
      ack_in = 2'b11;
      step();
      rst = 1'b0;
      check("r30_dout", 32'(dout), 32'h0);
      check("r30_ack", 32'(ack_out), 32'h0);
      check("r30_err", 32'(err), 32'h0);
      check("r30_cnt", 32'(tok_cnt), 32'h0);

      for (int i = 0; i < 65535; i++) begin
         token(6'b101010);
      end
      check("wrap_pre", 32'(tok_cnt), 32'hFFFF);
      din    = 6'b010101;
      ack_in = 2'b00;
      step();
      check("wrap_cnt", 32'(tok_cnt), 32'h0);
      check("wrap_ack", 32'(ack_out), 32'h1);
      check("wrap_dout", 32'(dout), 32'h15);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/ncl_stage_sync.md
NCL_STAGE_SYNC -- requirements
Module: ncl_stage_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the number of logical dual-rail bits carried.
REQ-002 The block SHALL have parameter N_ACK, default 2, giving the number of downstream consumers acknowledging the stage.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port din, input, 2*WIDTH bits, dual-rail data; pair i is din[2i+1] true rail and din[2i] false rail.
REQ-006 The block SHALL have port ack_in, input, N_ACK bits, consumer acknowledges; 1 = consumer holds DATA.
REQ-007 The block SHALL have port dout, output, 2*WIDTH bits, registered dual-rail data, same rail pairing as din.
REQ-008 The block SHALL have port ack_out, output, 1 bit, acknowledge to producer; 1 = DATA captured, producer sends NULL.
REQ-009 The block SHALL have port err, output, 1 bit, high while in ERROR.
REQ-010 The block SHALL have port tok_cnt, output, 16 bits, count of DATA tokens accepted.

Function
REQ-011 din is DATA-complete when every pair is exactly 01 or 10, NULL-complete when all rails are 0, and ILLEGAL when any pair is 11; otherwise it is partial.
REQ-012 The FSM SHALL have states NULL_HELD (ack_out=0), DATA_HELD (ack_out=1) and ERROR (ack_out=0, err=1).
REQ-013 NULL_HELD->DATA_HELD SHALL occur at the edge where din is DATA-complete and all ack_in bits are 0; dout<=din on that edge.
REQ-014 DATA_HELD->NULL_HELD SHALL occur at the edge where din is NULL-complete and all ack_in bits are 1; dout<=0 on that edge.
REQ-015 Under any other combination (partial din, or mixed ack_in), state and dout SHALL hold; this is a clocked C-element.
REQ-016 ILLEGAL din in NULL_HELD or DATA_HELD SHALL move to ERROR at that edge, with priority over REQ-013/014; dout<=0 on that edge.
REQ-017 ERROR SHALL be absorbing: dout=0, ack_out=0, inputs ignored until rst.
REQ-018 tok_cnt SHALL increment by 1 on each NULL_HELD->DATA_HELD transition and wrap 16'hFFFF->16'h0000.
REQ-019 Latency from qualifying inputs to ack_out/dout change SHALL be exactly one clk edge; outputs are register-driven only.

Reset
REQ-020 At an rst=1 edge: state=NULL_HELD, dout=0, ack_out=0, err=0, tok_cnt=0, regardless of prior state (including mid-DATA and ERROR).
REQ-021 rst SHALL take priority over all transitions in the same cycle.

Structure
REQ-022 Shared package ncl_pkg SHALL hold the state enum and rail-code constants (NULL=2'b00, F=2'b01, T=2'b10, ILL=2'b11).
REQ-023 Completion/illegal detection over WIDTH pairs SHALL be a combinational sub-module ncl_completion (outputs data_cmp, null_cmp, illegal).
REQ-024 The completion width SHALL cover all WIDTH pairs.

Verification (WIDTH=3, N_ACK=2)
REQ-025 rst=1 then 0, din=0, ack_in=00 -> dout=0, ack_out=0, err=0, tok_cnt=0.
REQ-026 din=6'b100110 (value 101), ack_in=00 -> next edge dout=6'b100110, ack_out=1, tok_cnt=1.
REQ-027 In DATA_HELD, din=0, ack_in=01 for 5 cycles -> hold; then ack_in=11 -> next edge dout=0, ack_out=0.
REQ-028 In NULL_HELD, partial din=6'b100100 for 4 cycles -> no capture; then 6'b100101 -> capture; in DATA_HELD, din=6'b110110 -> ERROR, err=1, dout=0; rst then exits ERROR.
REQ-029 Preload 65535 tokens by handshake -> tok_cnt=16'hFFFF; one more token -> 16'h0000.
REQ-030 rst asserted in DATA_HELD with ack_in=11 and NULL din -> next edge all outputs at reset values, no NULL transition counted.
